multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiplier/divider that serves the execute stage of the five-stage pipeline.
- The execute stage issues a MULT or DIV when that instruction enters X. This block runs the fixed-latency iteration and returns the result plus an exception flag.
- Its data_resultRDY pulse is the multDivReady input to the pipeline stall control, which holds dependent instructions in D until the pulse arrives.

Parameters:
- WIDTH, 32, operand and result width in bits. Iteration count equals WIDTH.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_operandA  input  WIDTH  multiplicand or dividend, two's complement. Sampled only on the start edge.
- data_operandB  input  WIDTH  multiplier or divisor, two's complement. Sampled only on the start edge.
- ctrl_MULT  input  1  start-multiply strobe, one cycle wide.
- ctrl_DIV  input  1  start-divide strobe, one cycle wide.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero flag for the completed operation.
- data_resultRDY  output  1  one-cycle completion pulse (multDivReady).
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset is synchronous and active-high. When reset=1 at a clock edge:
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - The iteration counter and internal registers clear. An in-flight operation is abandoned and produces no RDY pulse.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL when ctrl_MULT=1 at an edge.
  - IDLE -> DIV when ctrl_DIV=1 (and ctrl_MULT=0) at an edge.
  - MUL/DIV -> DONE after WIDTH iteration edges.
  - DONE -> IDLE on the next edge, or directly to MUL/DIV if a new strobe is present on that edge.
- Start edge E0:
  - Operands are latched, the operation is recorded, the counter loads 0, and busy=1 from E0.
  - Later changes on the operand inputs have no effect.
- Timing:
  - One iteration per edge, E1..E32.
  - At edge E33, data_result and data_exception are written, data_resultRDY=1 and busy=0.
  - data_resultRDY returns to 0 at E34.
  - Start-to-RDY latency is fixed at WIDTH+1 = 33 cycles for both operations, including the divide-by-zero case.
- data_result and data_exception hold their values from E33 until the next completion or reset. They are never changed mid-operation.
- Simultaneous ctrl_MULT and ctrl_DIV: MULT wins and DIV is ignored.
- Strobe while busy: the current operation is aborted without an RDY pulse, and the new one restarts at that edge with fresh operands. Stall control guarantees this does not happen in normal flow.
- Multiply:
  - Radix-2 shift-add with sign correction, using a 2*WIDTH-bit signed product.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff product[2*WIDTH-1:WIDTH-1] is not all equal, i.e. the product does not fit in WIDTH signed bits.
- Divide:
  - Non-restoring divide on magnitudes; the quotient is negated if the operand signs differ.
  - Truncates toward zero. The remainder is discarded.
  - Divisor=0: data_result=0 and data_exception=1.
  - Dividend=0x80000000 with divisor=0xFFFFFFFF: data_result=0x80000000 and data_exception=1.
  - Otherwise data_exception=0.
- There is no internal pipelining: exactly one operation is in flight at a time.

Test Plan:
1. Reset, then pulse ctrl_MULT with A=7, B=-6 -> busy=1 from E0; data_resultRDY=1 only in the cycle after E33; data_result=0xFFFFFFD6 (-42); data_exception=0.
2. ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1 at E33. Repeat with A=0x8000, B=0x10000 -> data_result=0x80000000, data_exception=1.
3. ctrl_DIV with A=-7, B=2 -> data_result=0xFFFFFFFD (-3), exception=0. Then A=100, B=0 -> data_result=0, exception=1, RDY still exactly at E33.
4. ctrl_DIV with A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=1.
5. Assert ctrl_MULT and ctrl_DIV on the same edge with A=5, B=3 -> result=15 (multiply). At E10, pulse ctrl_DIV with A=9, B=3 -> no RDY at the original E33; RDY 33 cycles after the restart with result=3.
6. Start a multiply, then assert reset at E20 -> all outputs 0 on the next edge and no RDY pulse ever for that operation. A new ctrl_MULT with 2×3 after reset -> result=6 at its own E33.

Source files
------------

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed multiply/divide for the execute stage
// Fixed WIDTH+1 cycle latency from start strobe to a one-cycle completion pulse.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]    r_count;
  logic [WIDTH+1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic             r_neg;
  logic             r_op_div;
  logic             r_div0;
  logic             r_dovf;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;

  logic             w_start;
  logic             w_last;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH+1:0] w_dsh;
  logic [WIDTH+1:0] w_dres;
  logic [2*WIDTH-1:0] w_pmag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]   w_ptop;
  logic             w_mexc;
  logic [WIDTH-1:0] w_quot;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_count == CW'(WIDTH - 1));

  assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Shift-add step: add multiplicand when multiplier LSB is set, then shift {hi,lo} right.
  assign w_msum = {1'b0, r_hi[WIDTH-1:0]} + {1'b0, (r_lo[0] ? r_m : {WIDTH{1'b0}})};

  // Non-restoring step: sign of the partial remainder picks add or subtract.
  assign w_dsh  = {r_hi[WIDTH:0], r_lo[WIDTH-1]};
  assign w_dres = r_hi[WIDTH+1] ? (w_dsh + {2'b00, r_m}) : (w_dsh - {2'b00, r_m});

  assign w_pmag = {r_hi[WIDTH-1:0], r_lo};
  assign w_prod = r_neg ? -w_pmag : w_pmag;
  assign w_ptop = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_mexc = ~((&w_ptop) | ~(|w_ptop));
  assign w_quot = r_neg ? -r_lo : r_lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ctrl_MULT) begin
      w_state_nxt = S_MUL;
    end else if (ctrl_DIV) begin
      w_state_nxt = S_DIV;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_MUL:   w_state_nxt = w_last ? S_DONE : S_MUL;
        S_DIV:   w_state_nxt = w_last ? S_DONE : S_DIV;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_neg    <= 1'b0;
      r_op_div <= 1'b0;
      r_div0   <= 1'b0;
      r_dovf   <= 1'b0;
    end else if (w_start) begin
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= w_mag_a;
      r_m      <= w_mag_b;
      r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_op_div <= ~ctrl_MULT;
      r_div0   <= (data_operandB == '0);
      r_dovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
    end else if (r_state == S_MUL) begin
      r_count <= r_count + 1'b1;
      r_hi    <= {2'b00, w_msum[WIDTH:1]};
      r_lo    <= {w_msum[0], r_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      r_count <= r_count + 1'b1;
      r_hi    <= w_dres;
      r_lo    <= {r_lo[WIDTH-2:0], ~w_dres[WIDTH+1]};
    end
  end

  // Results only move on the completion edge so the pipeline sees stable values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (r_state == S_DONE) begin
        r_rdy <= 1'b1;
        if (!r_op_div) begin
          r_result    <= w_prod[WIDTH-1:0];
          r_exception <= w_mexc;
        end else if (r_div0) begin
          r_result    <= '0;
          r_exception <= 1'b1;
        end else begin
          r_result    <= w_quot;
          r_exception <= r_dovf;
        end
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != S_IDLE);

endmodule
